// File: rtl/ad100_lsu.sv
// ad100_lsu - load/store unit between the ad100 execute stage and a
// single-port, word-wide RAM with a one-cycle synchronous read.
//
// Handles one request at a time. Loads read the addressed word and extract
// a byte, half or word with sign or zero extension. Sub-word stores
// (SB/SH) read the word, merge the new lane and write it back. Full-word
// stores (SW) write directly. Misaligned accesses and illegal funct3
// encodings complete with resp_err=1 and never touch the RAM.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. The response is
// a single-cycle resp_valid pulse, with resp_rdata/resp_err valid in that
// cycle. There is no backpressure on the response side.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   req_valid/ready   request handshake
//   req_write         1 = store, 0 = load
//   req_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr          byte address (bits above ADDR_WIDTH+1 ignored)
//   req_wdata         store data (low byte/half used for SB/SH)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and errors)
//   resp_err          misaligned or illegal access
//   mem_addr          RAM word address
//   mem_re / mem_we   RAM read / full-word write enables
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data (valid the cycle after mem_re)
//   dbg_state_o       current FSM state, for observation only
module ad100_lsu #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH+1:0]  addr_q;
    logic [2:0]             funct3_q;
    logic                   write_q;
    logic [15:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic [31:0]            mem_wdata_q;

    logic                   accept;
    logic                   acc_err;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic [31:0]            load_v;
    logic [31:0]            merged_v;

    // Upper address bits are intentionally dropped: the RAM image wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign accept = req_valid & req_ready;

    // Alignment / encoding check on the live request, used only at accept.
    always_comb begin
        acc_err = 1'b1;
        case (req_funct3)
            3'b000:  acc_err = 1'b0;
            3'b001:  acc_err = req_addr[0];
            3'b010:  acc_err = |req_addr[1:0];
            3'b100:  acc_err = req_write;
            3'b101:  acc_err = req_write | req_addr[0];
            default: acc_err = 1'b1;
        endcase
    end

    // Lane extraction and store merge, both working on the word read in WAIT.
    always_comb begin
        byte_v   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_v   = mem_rdata;
        merged_v = mem_rdata;
        case (funct3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_v = {24'h0, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b101:  load_v = {16'h0, half_v};
            default: load_v = mem_rdata;
        endcase
        if (funct3_q[1:0] == 2'b00) begin
            merged_v[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged_v[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = S_RESP;
                    end else if (req_write && req_funct3 == 3'b010) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = S_WAIT;
            S_WAIT:  state_d = write_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            funct3_q    <= 3'b000;
            write_q     <= 1'b0;
            wdata_q     <= 16'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= req_addr[ADDR_WIDTH+1:0];
                funct3_q    <= req_funct3;
                write_q     <= req_write;
                wdata_q     <= req_wdata[15:0];
                rdata_q     <= 32'h0;
                err_q       <= acc_err;
                // Ready-made write word for SW; SB/SH overwrite it in WAIT.
                mem_wdata_q <= req_wdata;
            end
            if (state_q == S_WAIT) begin
                if (write_q) begin
                    mem_wdata_q <= merged_v;
                end else begin
                    rdata_q <= load_v;
                end
            end
        end
    end

    // Strobes are gated by reset so an aborted request never reaches the RAM.
    assign req_ready   = (state_q == S_IDLE) & ~reset;
    assign mem_re      = (state_q == S_RD)   & ~reset;
    assign mem_we      = (state_q == S_WR)   & ~reset;
    assign resp_valid  = (state_q == S_RESP) & ~reset;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_addr    = addr_q[ADDR_WIDTH+1:2];
    assign mem_wdata   = mem_wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ad100_lsu.sv
module tb_ad100_lsu;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [2:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    // RAM model plus a side port for preloading words between scenarios.
    logic [31:0]   ram [256];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    int re_cnt = 0;
    int we_cnt = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    ad100_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state_o)
    );

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request and measure cycles from accept to resp_valid (99 = none).
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er);
        int w;
        w = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; rd = 32'hx; er = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {req_ready, resp_valid, resp_err, mem_re, mem_we});
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h wdata=%h want 0/0", resp_rdata, mem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || dbg_state_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle got ready=%b state=%0d want 1/0", req_ready, dbg_state_o);
        end
    endtask

    task automatic test_loads();
        logic [31:0] a_tab [7];
        logic [2:0]  f_tab [7];
        logic [31:0] e_tab [7];
        int lat;
        logic [31:0] rd;
        logic er;
        a_tab = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h2, 32'h0, 32'h400};
        f_tab = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b010};
        e_tab = '{32'hFFFFFF84, 32'h00000084, 32'h0000007F, 32'hFFFF80F2,
                  32'h000080F2, 32'h80F27F84, 32'h80F27F84};
        preload(8'd0, 32'h80F27F84);
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, f_tab[i], a_tab[i], 32'h0, lat, rd, er);
            checks++;
            if (rd !== e_tab[i] || er !== 1'b0 || lat != 3) begin
                errors++;
                $display("FAIL load_%0d got rdata=%h err=%b lat=%0d want %h/0/3",
                         i, rd, er, lat, e_tab[i]);
            end
        end
    endtask

    task automatic test_stores();
        int lat;
        logic [31:0] rd;
        logic er;
        preload(8'd0, 32'h80F27F84);
        do_req(1'b1, 3'b000, 32'h1, 32'h000000AB, lat, rd, er);
        checks++;
        if (ram[0] !== 32'h80F2AB84 || lat != 4 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb got word=%h lat=%0d rdata=%h err=%b want 80f2ab84/4/0/0",
                     ram[0], lat, rd, er);
        end
        do_req(1'b1, 3'b001, 32'h2, 32'hFFFF1234, lat, rd, er);
        checks++;
        if (ram[0] !== 32'h1234AB84 || lat != 4 || er !== 1'b0) begin
            errors++;
            $display("FAIL sh got word=%h lat=%0d err=%b want 1234ab84/4/0", ram[0], lat, er);
        end
        do_req(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, lat, rd, er);
        checks++;
        if (ram[0] !== 32'hDEADBEEF || lat != 2 || rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw got word=%h lat=%0d rdata=%h err=%b want deadbeef/2/0/0",
                     ram[0], lat, rd, er);
        end
    endtask

    task automatic test_errors();
        logic        w_tab [5];
        logic [2:0]  f_tab [5];
        logic [31:0] a_tab [5];
        int lat, re0, we0;
        logic [31:0] rd;
        logic er;
        w_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        f_tab = '{3'b010, 3'b001, 3'b001, 3'b011, 3'b100};
        a_tab = '{32'h2, 32'h3, 32'h1, 32'h0, 32'h0};
        preload(8'd0, 32'h80F27F84);
        for (int i = 0; i < 5; i++) begin
            re0 = re_cnt; we0 = we_cnt;
            do_req(w_tab[i], f_tab[i], a_tab[i], 32'hFFFFFFFF, lat, rd, er);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
                errors++;
                $display("FAIL err_%0d got err=%b rdata=%h lat=%0d want 1/0/1", i, er, rd, lat);
            end
            checks++;
            if (re_cnt != re0 || we_cnt != we0 || ram[0] !== 32'h80F27F84) begin
                errors++;
                $display("FAIL err_mem_%0d got re=%0d we=%0d word=%h want 0/0/80f27f84",
                         i, re_cnt - re0, we_cnt - we0, ram[0]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int we0, resp0, lat;
        logic [31:0] rd;
        logic er;
        preload(8'd0, 32'h80F27F84);
        @(negedge clk);
        we0 = we_cnt; resp0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (mem_re !== 1'b1) begin
            errors++;
            $display("FAIL abort_rd got mem_re=%b want 1", mem_re);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_re !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_gate got re=%b ready=%b want 0/0", mem_re, req_ready);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (we_cnt != we0 || resp_cnt != resp0 || ram[0] !== 32'h80F27F84 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort got we=%0d resp=%0d word=%h ready=%b want 0/0/80f27f84/1",
                     we_cnt - we0, resp_cnt - resp0, ram[0], req_ready);
        end
        do_req(1'b0, 3'b100, 32'h0, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'h00000084 || er !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL abort_lbu got rdata=%h err=%b lat=%0d want 00000084/0/3", rd, er, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f_tab [3];
        logic [31:0] a_tab [3];
        logic [31:0] e_tab [3];
        int acc, rsp, last_acc;
        logic go;
        f_tab = '{3'b010, 3'b001, 3'b100};
        a_tab = '{32'h0, 32'h4, 32'h7};
        e_tab = '{32'h80F27F84, 32'h00003344, 32'h00000011};
        preload(8'd0, 32'h80F27F84);
        preload(8'd1, 32'h11223344);
        @(negedge clk);
        acc = 0; rsp = 0; last_acc = -1;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = f_tab[0]; req_addr = a_tab[0];
        for (int cyc = 0; cyc < 60 && rsp < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (resp_valid === 1'b1) begin
                checks++;
                if (resp_rdata !== e_tab[rsp] || resp_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data_%0d got %h err=%b want %h/0",
                             rsp, resp_rdata, resp_err, e_tab[rsp]);
                end
                rsp++;
            end
            go = req_ready && req_valid;
            if (go) begin
                checks++;
                if (acc != rsp || (last_acc >= 0 && cyc - last_acc != 4)) begin
                    errors++;
                    $display("FAIL b2b_accept_%0d got inflight=%0d gap=%0d want 0/4",
                             acc, acc - rsp, cyc - last_acc);
                end
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            if (go) begin
                acc++;
                if (acc == 3) begin
                    req_valid = 1'b0;
                end else begin
                    req_funct3 = f_tab[acc]; req_addr = a_tab[acc];
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (acc != 3 || rsp != 3) begin
            errors++;
            $display("FAIL b2b_count got acc=%0d rsp=%0d want 3/3", acc, rsp);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_op();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
